angle_reducer: RTL and testbench

ANGLE_REDUCER -- requirements
Module: angle_reducer

---
 rtl/angle_reducer.sv | 172 +++++++++++++++++
 tb/tb_angle_reducer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_reducer.sv
// angle_reducer: reduces an IEEE 754 single-precision angle (degrees) into
// signed fixed point with FRAC_W fractional bits.
//   mode 0 : result in [-180,180)
//   mode 1 : result in [-90,90], flip=1 when the cosine sign must be negated
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, angle_in[31:0], mode, in_tag   : request side
//   out_valid/out_ready, angle_out, flip, err, out_tag : result side
// One request in flight at a time. Latency is 18 edges for normal inputs
// and 1 edge for NaN/Inf/|x| >= 2^23 (err=1).
module angle_reducer #(
  parameter int unsigned FRAC_W = 6,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned TAG_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      angle_in,
  input  logic             mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] angle_out,
  output logic             flip,
  output logic             err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned MAG_W = 23 + FRAC_W;
  localparam int unsigned CMP_W = MAG_W + 10;

  localparam logic [MAG_W-1:0] FIX_90  = MAG_W'(90)  << FRAC_W;
  localparam logic [MAG_W-1:0] FIX_180 = MAG_W'(180) << FRAC_W;
  localparam logic [MAG_W-1:0] FIX_270 = MAG_W'(270) << FRAC_W;
  localparam logic [MAG_W-1:0] FIX_360 = MAG_W'(360) << FRAC_W;
  localparam logic [OUT_W-1:0] O_180   = OUT_W'(180) << FRAC_W;
  localparam logic [OUT_W-1:0] O_360   = OUT_W'(360) << FRAC_W;

  typedef enum logic [2:0] {IDLE, CONV, REDUCE, FOLD, OUT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        ang_q, ang_d;
  logic               mode_q, mode_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sign_q, sign_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [3:0]         k_q, k_d;
  logic [OUT_W-1:0]   aout_q, aout_d;
  logic               flip_q, flip_d;
  logic               err_q, err_d;
  logic [TAG_W-1:0]   otag_q, otag_d;

  logic [7:0]         exp_f;
  logic [23:0]        mant;
  logic [MAG_W-1:0]   conv_mag;
  logic [CMP_W-1:0]   step;
  logic [MAG_W-1:0]   r;
  logic [OUT_W-1:0]   ro;

  assign exp_f = ang_q[30:23];
  assign mant  = {1'b1, ang_q[22:0]};
  // value = mant * 2^(exp-150) ; scaled by 2^FRAC_W and truncated. Only
  // meaningful for exp < 150, where the shift is >= 1 and fits MAG_W bits.
  assign conv_mag = MAG_W'({mant, {FRAC_W{1'b0}}} >> (8'd150 - exp_f));
  assign step     = CMP_W'(360) << (k_q + FRAC_W);

  always_comb begin
    state_d = state_q;
    ang_d   = ang_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    k_d     = k_q;
    aout_d  = aout_q;
    flip_d  = flip_q;
    err_d   = err_q;
    otag_d  = otag_q;
    r       = mag_q;
    ro      = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ang_d   = angle_in;
          mode_d  = mode;
          tag_d   = in_tag;
          state_d = CONV;
        end
      end
      CONV: begin
        sign_d = ang_q[31];
        k_d    = 4'd15;
        if (exp_f == 8'hFF || exp_f >= 8'd150) begin
          aout_d  = '0;
          flip_d  = 1'b0;
          err_d   = 1'b1;
          otag_d  = tag_q;
          state_d = OUT;
        end else begin
          mag_d   = (exp_f == 8'd0) ? '0 : conv_mag;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        // Binary long-division style: 16 conditional subtractions of 360*2^k.
        if (CMP_W'(mag_q) >= step) mag_d = mag_q - MAG_W'(step);
        if (k_q == 4'd0) state_d = FOLD;
        else             k_d = k_q - 4'd1;
      end
      FOLD: begin
        if (sign_q && mag_q != '0) r = FIX_360 - mag_q;
        ro     = OUT_W'(r);
        flip_d = 1'b0;
        if (!mode_q) begin
          aout_d = (r < FIX_180) ? ro : ro - O_360;
        end else if (r <= FIX_90) begin
          aout_d = ro;
        end else if (r < FIX_270) begin
          aout_d = O_180 - ro;
          flip_d = 1'b1;
        end else begin
          aout_d = ro - O_360;
        end
        err_d   = 1'b0;
        otag_d  = tag_q;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ang_q   <= '0;
      mode_q  <= 1'b0;
      tag_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      k_q     <= '0;
      aout_q  <= '0;
      flip_q  <= 1'b0;
      err_q   <= 1'b0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      ang_q   <= ang_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      k_q     <= k_d;
      aout_q  <= aout_d;
      flip_q  <= flip_d;
      err_q   <= err_d;
      otag_q  <= otag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign angle_out = aout_q;
  assign flip      = flip_q;
  assign err       = err_q;
  assign out_tag   = otag_q;

endmodule

// File: tb/tb_angle_reducer.sv
module tb_angle_reducer;

  localparam int F    = 6;
  localparam int OW   = 16;
  localparam int TW   = 2;
  localparam longint R360 = 360 * 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   angle_in;
  logic          mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] angle_out;
  logic          flip;
  logic          err;
  logic [TW-1:0] out_tag;

  angle_reducer #(.FRAC_W(F), .OUT_W(OW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .angle_in(angle_in), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .angle_out(angle_out),
    .flip(flip), .err(err), .out_tag(out_tag)
  );

  typedef struct {
    longint  ang;
    logic    fl;
    logic    er;
    logic [TW-1:0] tag;
    longint  lat;
    longint  acc;
  } exp_t;

  exp_t   q[$];
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     rbp   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: exact real-valued decode, truncate to 1/64 degree, then modulo 360.
  function automatic exp_t model(input logic [31:0] a, input logic m, input logic [TW-1:0] t);
    exp_t   e;
    int     ef;
    int     sh;
    real    v;
    longint fx;
    longint r;
    e.tag = t; e.fl = 1'b0; e.er = 1'b0; e.ang = 0; e.lat = 18; e.acc = 0;
    ef = int'(a[30:23]);
    if (ef == 255 || ef >= 150) begin
      e.er = 1'b1; e.lat = 1;
      return e;
    end
    fx = 0;
    if (ef != 0) begin
      v  = real'(int'({1'b1, a[22:0]}));
      sh = ef - 150 + F;
      if (sh >= 0) for (int i = 0; i < sh; i++) v = v * 2.0;
      else         for (int i = 0; i < -sh; i++) v = v / 2.0;
      fx = longint'($floor(v));
    end
    r = fx % R360;
    if (a[31] && r != 0) r = R360 - r;
    if (!m) begin
      e.ang = (r < R360 / 2) ? r : r - R360;
    end else if (r <= R360 / 4) begin
      e.ang = r;
    end else if (r < 3 * R360 / 4) begin
      e.ang = R360 / 2 - r; e.fl = 1'b1;
    end else begin
      e.ang = r - R360;
    end
    return e;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic m, input logic [TW-1:0] t,
                      input exp_t e, input bit push);
    int n = 0;
    exp_t x;
    in_valid = 1'b1; angle_in = a; mode = m; in_tag = t;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rbp) out_ready = ($urandom_range(0, 2) != 0);
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    x = e; x.acc = cyc;
    if (push) q.push_back(x);
    in_valid = 1'b0;
    angle_in = $urandom; mode = 1'($urandom); in_tag = TW'($urandom);
  endtask

  task automatic send_const(input logic [31:0] a, input logic m, input longint ang,
                            input logic fl, input logic er);
    exp_t e;
    logic [TW-1:0] t;
    t = TW'($urandom);
    e.ang = ang; e.fl = fl; e.er = er; e.tag = t; e.lat = er ? 1 : 18; e.acc = 0;
    send(a, m, t, e, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (rbp) out_ready = ($urandom_range(0, 2) != 0);
    end
    check("drain_timeout", longint'(q.size()), 0);
  endtask

  // Monitor: every cycle with out_valid, compare against the queue head.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = q[0];
          if (!seen) begin
            check("latency", cyc - e.acc, e.lat);
            seen = 1'b1;
          end
          check("angle_out", longint'($signed(angle_out)), e.ang);
          check("flip", longint'(flip), longint'(e.fl));
          check("err", longint'(err), longint'(e.er));
          check("out_tag", longint'(out_tag), longint'(e.tag));
          check("in_ready_busy", longint'(in_ready), 0);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] dv_a   [11] = '{32'h42340000, 32'h43340000, 32'h43340000, 32'hC3340000,
                               32'h43B40000, 32'h43B40000, 32'hC2340000, 32'h43C80000,
                               32'hC1B00000, 32'h80000000, 32'h80000000};
  logic        dv_m   [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  longint      dv_ang [11] = '{2880, 0, -11520, 0, 0, 0, -2880, 2560, -1408, 0, 0};
  logic        dv_fl  [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin : stim
    exp_t        e;
    logic [31:0] a;
    logic [7:0]  ex;
    logic        m;
    logic [TW-1:0] t;
    int          n;

    rst = 1'b0; in_valid = 1'b0; angle_in = '0; mode = 1'b0; in_tag = '0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_angle_out", longint'(angle_out), 0);
    check("rst_flip", longint'(flip), 0);
    check("rst_err", longint'(err), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed values
    for (int i = 0; i < 11; i++) send_const(dv_a[i], dv_m[i], dv_ang[i], dv_fl[i], 1'b0);
    send_const(32'h7F800000, 1'b0, 0, 1'b0, 1'b1);
    send_const(32'h4B189680, 1'b1, 0, 1'b0, 1'b1);
    drain();

    // Backpressure: hold out_ready low for 5 cycles after out_valid rises
    out_ready = 1'b0;
    send_const(32'h42340000, 1'b1, 2880, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("bp_out_valid_rise", longint'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_out_valid_hold", longint'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_out_valid_clear", longint'(out_valid), 0);
    check("bp_in_ready_back", longint'(in_ready), 1);
    check("bp_queue_popped", longint'(q.size()), 0);

    // Back-to-back tags 0..3
    for (int i = 0; i < 4; i++) begin
      a = 32'h43C80000;
      e = model(a, 1'b0, TW'(i));
      send(a, 1'b0, TW'(i), e, 1'b1);
    end
    drain();

    // Reset during the 8th REDUCE cycle
    e = model(32'h43C80000, 1'b1, '0);
    send(32'h43C80000, 1'b1, '0, e, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_angle_out", longint'(angle_out), 0);
    @(negedge clk); rst = 1'b1;
    #1 check("postrst_in_ready", longint'(in_ready), 1);
    repeat (25) @(posedge clk);
    #1;
    check("no_stale_result", longint'(out_valid), 0);

    // Randomized requests with random backpressure
    rbp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 19);
      if (n == 0)      ex = 8'd0;
      else if (n == 1) ex = 8'hFF;
      else             ex = 8'($urandom_range(110, 152));
      a = {1'($urandom), ex, 23'($urandom)};
      m = 1'($urandom);
      t = TW'($urandom);
      e = model(a, m, t);
      send(a, m, t, e, 1'b1);
    end
    drain();
    rbp = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
